// File: rtl/uart_port.sv
// uart_port: memory-mapped 8N1 UART with a small transmit FIFO, a one-byte
// receive holding register and a programmable 16-bit baud divisor.
// Optional build macro UART_LOOPBACK_EN enables the internal loopback bit
// (CTRL bit2). Without it the bit reads 0 and cannot be set.
module uart_port #(
    parameter logic [15:0] DEFAULT_DIV   = 16'd26,
    parameter int          TX_DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       wren,
    input  logic       rden,
    input  logic [3:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       tx,
    input  logic       rx
);
    localparam int DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int PW    = TX_DEPTH_LOG2 + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

`ifdef UART_LOOPBACK_EN
    localparam logic [7:0] CTRL_MASK = 8'h07;
`else
    localparam logic [7:0] CTRL_MASK = 8'h03;
`endif

    logic [15:0] div_q, div_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  data_out_q, data_out_d;
    logic [7:0]  fifo_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]  tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;
    logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic [1:0]  rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_full_q, rx_full_d, oe_q, oe_d, fe_q, fe_d;

    logic wr_en, rd_en, push_req, push_ok, tx_pop, rx_pop, rx_done;
    logic fifo_empty, fifo_full, loop_en, rx_src;
    logic [7:0] fifo_head, status, rd_val;

    assign wr_en    = ce & wren;
    assign rd_en    = ce & rden;
    assign push_req = wr_en && (addr == 4'd0);
    assign rx_pop   = rd_en && (addr == 4'd0);

`ifdef UART_LOOPBACK_EN
    assign loop_en = ctrl_q[2];
`else
    assign loop_en = 1'b0;
`endif
    // In loopback the receiver listens to the transmitter and the pin idles
    assign rx_src   = loop_en ? tx_q : rx;
    assign tx       = loop_en ? 1'b1 : tx_q;
    assign data_out = data_out_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign fifo_head  = fifo_mem_q[rd_ptr_q[PW-2:0]];
    // A push into a full FIFO still lands if the transmitter pops on the same edge
    assign push_ok    = push_req && (!fifo_full || tx_pop);
    assign status     = {3'b000, fe_q, oe_q, rx_full_q, fifo_full,
                         fifo_empty && (tx_state_q == S_IDLE)};

    // Transmit state machine: counter reloads from DIV at every bit boundary
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                if (ctrl_q[0] && !fifo_empty) begin
                    tx_state_d = S_START; tx_cnt_d = div_q;
                    tx_shift_d = fifo_head; tx_d = 1'b0; tx_pop = 1'b1;
                end
            end
            S_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = S_DATA; tx_cnt_d = div_q;
                    tx_bit_d = 3'd0; tx_d = tx_shift_q[0];
                end else tx_cnt_d = tx_cnt_q - 16'd1;
            end
            S_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = div_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP; tx_d = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else tx_cnt_d = tx_cnt_q - 16'd1;
            end
            default: begin
                if (tx_cnt_q == 16'd0) begin
                    if (ctrl_q[0] && !fifo_empty) begin
                        tx_state_d = S_START; tx_cnt_d = div_q;
                        tx_shift_d = fifo_head; tx_d = 1'b0; tx_pop = 1'b1;
                    end else tx_state_d = S_IDLE;
                end else tx_cnt_d = tx_cnt_q - 16'd1;
            end
        endcase
    end

    // Receive synchronizer and state machine; samples mid-bit after a half-period start check
    always_comb begin
        rx_s1_d    = rx_src;
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (ctrl_q[1] && rx_prev_q && !rx_s2_q) begin
                    rx_state_d = S_START; rx_cnt_d = {1'b0, div_q[15:1]};
                end
            end
            S_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (rx_s2_q) rx_state_d = S_IDLE;
                    else begin
                        rx_state_d = S_DATA; rx_cnt_d = div_q; rx_bit_d = 3'd0;
                    end
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
            S_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = div_q;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else rx_bit_d = rx_bit_q + 3'd1;
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
            default: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_done = 1'b1; rx_state_d = S_IDLE;
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
        endcase
    end

    // Bus registers, receive holding register and error flags
    always_comb begin
        div_d      = div_q;
        ctrl_d     = ctrl_q;
        rx_data_d  = rx_data_q;
        rx_full_d  = rx_full_q;
        oe_d       = oe_q;
        fe_d       = fe_q;
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = tx_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        if (wr_en) begin
            case (addr)
                4'd1: begin
                    if (data_in[3]) oe_d = 1'b0;
                    if (data_in[4]) fe_d = 1'b0;
                end
                4'd2: div_d[7:0]  = data_in;
                4'd3: div_d[15:8] = data_in;
                4'd4: ctrl_d      = data_in & CTRL_MASK;
                default: ;
            endcase
        end
        if (rx_pop) rx_full_d = 1'b0;
        // A pop on the completion edge frees the holder, so no overrun
        if (rx_done) begin
            if (!rx_full_q || rx_pop) begin
                rx_data_d = rx_shift_q;
                rx_full_d = 1'b1;
                if (!rx_s2_q) fe_d = 1'b1;
            end else oe_d = 1'b1;
        end
        case (addr)
            4'd0:    rd_val = rx_data_q;
            4'd1:    rd_val = status;
            4'd2:    rd_val = div_q[7:0];
            4'd3:    rd_val = div_q[15:8];
            4'd4:    rd_val = ctrl_q;
            default: rd_val = 8'h00;
        endcase
        data_out_d = rd_en ? rd_val : data_out_q;
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem_q[wr_ptr_q[PW-2:0]] <= data_in;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q <= DEFAULT_DIV;   ctrl_q <= 8'h03;    data_out_q <= 8'h00;
            wr_ptr_q <= '0;         rd_ptr_q <= '0;
            tx_state_q <= S_IDLE;   tx_cnt_q <= 16'd0;  tx_bit_q <= 3'd0;
            tx_shift_q <= 8'h00;    tx_q <= 1'b1;
            rx_s1_q <= 1'b1;        rx_s2_q <= 1'b1;    rx_prev_q <= 1'b1;
            rx_state_q <= S_IDLE;   rx_cnt_q <= 16'd0;  rx_bit_q <= 3'd0;
            rx_shift_q <= 8'h00;    rx_data_q <= 8'h00;
            rx_full_q <= 1'b0;      oe_q <= 1'b0;       fe_q <= 1'b0;
        end else begin
            div_q <= div_d;         ctrl_q <= ctrl_d;   data_out_q <= data_out_d;
            wr_ptr_q <= wr_ptr_d;   rd_ptr_q <= rd_ptr_d;
            tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d;
            tx_shift_q <= tx_shift_d; tx_q <= tx_d;
            rx_s1_q <= rx_s1_d;     rx_s2_q <= rx_s2_d; rx_prev_q <= rx_prev_d;
            rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d;
            rx_shift_q <= rx_shift_d; rx_data_q <= rx_data_d;
            rx_full_q <= rx_full_d; oe_q <= oe_d;       fe_q <= fe_d;
        end
    end
endmodule

// File: tb/tb_uart_port.sv
// Directed testbench for uart_port: register table, TX framing, FIFO drop,
// RX receive/overrun/framing/glitch, same-edge pop, loopback, mid-frame reset.
module tb_uart_port;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b0, wren = 1'b0, rden = 1'b0;
    logic [3:0] addr = 4'd0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       tx;
    logic       rx = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rd;

    uart_port dut (
        .clk(clk), .rst(rst), .ce(ce), .wren(wren), .rden(rden),
        .addr(addr), .data_in(data_in), .data_out(data_out),
        .tx(tx), .rx(rx)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_wr;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[22];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        ce = 1'b1; wren = 1'b1; addr = a; data_in = d;
        @(posedge clk); #1;
        ce = 1'b0; wren = 1'b0;
        $display("write addr=%0d data=%02h", a, d);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        ce = 1'b1; rden = 1'b1; addr = a;
        @(posedge clk); #1;
        d = data_out;
        ce = 1'b0; rden = 1'b0;
        $display("read  addr=%0d data=%02h", a, d);
    endtask

    task automatic read_check(input string name, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] v;
        bus_read(a, v);
        check8(name, v, exp);
    endtask

    // Expects to be entered just after the edge that starts the frame's START bit.
    // Frame at DIV=3: 10 bits of 4 clocks, start 0, LSB first, stop 1.
    task automatic tx_frame(input string name, input logic [7:0] b);
        logic exp_bit;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k / 4 == 0)      exp_bit = 1'b0;
            else if (k / 4 == 9) exp_bit = 1'b1;
            else                 exp_bit = b[k / 4 - 1];
            check8(name, {7'd0, tx}, {7'd0, exp_bit});
        end
        $display("tx frame %02h observed", b);
    endtask

    task automatic tx_idle(input string name, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            check8(name, {7'd0, tx}, 8'h01);
        end
    endtask

    // Must be entered at a negedge; drives 10 bits of 4 clocks each, ends with rx high
    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (4) @(negedge clk);
        end
        rx = stop;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        $display("rx frame %02h stop=%0d sent", b, stop);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        send_rx(b, stop);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 4'd1,  8'h00, 8'h01};
        vecs[1]  = '{0, 4'd2,  8'h00, 8'h1A};
        vecs[2]  = '{0, 4'd3,  8'h00, 8'h00};
        vecs[3]  = '{0, 4'd4,  8'h00, 8'h03};
        vecs[4]  = '{0, 4'd0,  8'h00, 8'h00};
        vecs[5]  = '{0, 4'd5,  8'h00, 8'h00};
        vecs[6]  = '{0, 4'd15, 8'h00, 8'h00};
        vecs[7]  = '{1, 4'd7,  8'hAA, 8'h00};
        vecs[8]  = '{0, 4'd7,  8'h00, 8'h00};
        vecs[9]  = '{1, 4'd4,  8'hFF, 8'h00};
`ifdef UART_LOOPBACK_EN
        vecs[10] = '{0, 4'd4,  8'h00, 8'h07};
`else
        vecs[10] = '{0, 4'd4,  8'h00, 8'h03};
`endif
        vecs[11] = '{1, 4'd4,  8'h03, 8'h00};
        vecs[12] = '{0, 4'd4,  8'h00, 8'h03};
        vecs[13] = '{1, 4'd3,  8'h12, 8'h00};
        vecs[14] = '{0, 4'd3,  8'h00, 8'h12};
        vecs[15] = '{1, 4'd2,  8'h03, 8'h00};
        vecs[16] = '{1, 4'd3,  8'h00, 8'h00};
        vecs[17] = '{0, 4'd2,  8'h00, 8'h03};
        vecs[18] = '{0, 4'd3,  8'h00, 8'h00};
        vecs[19] = '{1, 4'd1,  8'hFF, 8'h00};
        vecs[20] = '{0, 4'd1,  8'h00, 8'h01};
        vecs[21] = '{0, 4'd14, 8'h00, 8'h00};

        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check8("reset_data_out", data_out, 8'h00);
        check8("reset_tx", {7'd0, tx}, 8'h01);

        // Register table (ends with DIV=3, CTRL=3)
        for (int i = 0; i < 22; i++) begin
            if (vecs[i].is_wr) bus_write(vecs[i].a, vecs[i].d);
            else               read_check($sformatf("reg_vec%0d", i), vecs[i].a, vecs[i].exp);
        end

        // Single byte transmit
        bus_write(4'd0, 8'h55);
        check8("tx_idle_before", {7'd0, tx}, 8'h01);
        tx_frame("tx_55", 8'h55);
        @(posedge clk);
        read_check("tx_done_status", 4'd1, 8'h01);

        // FIFO fill with transmitter disabled, fifth byte dropped
        bus_write(4'd4, 8'h02);
        bus_write(4'd0, 8'h11);
        bus_write(4'd0, 8'h22);
        bus_write(4'd0, 8'h33);
        bus_write(4'd0, 8'h44);
        bus_write(4'd0, 8'hEE);
        read_check("fifo_full_status", 4'd1, 8'h02);
        bus_write(4'd4, 8'h03);
        tx_frame("tx_b2b_11", 8'h11);
        tx_frame("tx_b2b_22", 8'h22);
        tx_frame("tx_b2b_33", 8'h33);
        tx_frame("tx_b2b_44", 8'h44);
        tx_idle("tx_fifth_dropped", 40);
        read_check("b2b_done_status", 4'd1, 8'h01);

        // Receive, read, empty
        rx_frame(8'hA3, 1'b1);
        read_check("rx_full_status", 4'd1, 8'h05);
        read_check("rx_data_a3", 4'd0, 8'hA3);
        read_check("rx_empty_status", 4'd1, 8'h01);

        // Overrun keeps old byte, OE cleared by write-1
        rx_frame(8'hA3, 1'b1);
        rx_frame(8'h5A, 1'b1);
        read_check("oe_status", 4'd1, 8'h0D);
        bus_write(4'd1, 8'h08);
        read_check("oe_cleared", 4'd1, 8'h05);
        read_check("oe_old_byte", 4'd0, 8'hA3);
        read_check("oe_empty", 4'd1, 8'h01);

        // Framing error still stores the byte
        rx_frame(8'hC6, 1'b0);
        read_check("fe_status", 4'd1, 8'h15);
        read_check("fe_data", 4'd0, 8'hC6);
        read_check("fe_after_read", 4'd1, 8'h11);
        bus_write(4'd1, 8'h10);
        read_check("fe_cleared", 4'd1, 8'h01);

        // One-clock glitch is rejected as a false start
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        repeat (20) @(negedge clk);
        read_check("glitch_status", 4'd1, 8'h01);

        // DATA read on the completion edge: new byte stored, no overrun
        rx_frame(8'h11, 1'b1);
        @(negedge clk);
        fork
            send_rx(8'h22, 1'b1);
            begin
                repeat (40) @(posedge clk);
                bus_read(4'd0, rd);
            end
        join
        check8("same_edge_old", rd, 8'h11);
        repeat (4) @(negedge clk);
        read_check("same_edge_status", 4'd1, 8'h05);
        read_check("same_edge_new", 4'd0, 8'h22);
        read_check("same_edge_empty", 4'd1, 8'h01);

`ifdef UART_LOOPBACK_EN
        bus_write(4'd4, 8'h07);
        bus_write(4'd0, 8'h3C);
        tx_idle("loop_tx_high", 80);
        read_check("loop_status", 4'd1, 8'h05);
        read_check("loop_data", 4'd0, 8'h3C);
        bus_write(4'd4, 8'h03);
        read_check("loop_off_status", 4'd1, 8'h01);
`endif

        // Reset in the middle of a frame
        bus_write(4'd0, 8'h00);
        repeat (3) @(posedge clk); #1;
        check8("midframe_tx_low", {7'd0, tx}, 8'h00);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check8("reset_tx_high", {7'd0, tx}, 8'h01);
        @(negedge clk); rst = 1'b1;
        tx_idle("reset_frame_discarded", 20);
        read_check("reset_status", 4'd1, 8'h01);
        read_check("reset_div_lo", 4'd2, 8'h1A);
        read_check("reset_ctrl", 4'd4, 8'h03);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
